// File: rtl/iter_array_mult_if.sv
// Handshake and data bundle for the iterative array multiplier.
// The multiplier sits on the slave side. The operand source and result sink sit on the master side.
interface iter_array_mult_if #(
  parameter int WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 signed_mode;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   p;
  logic                 busy;

  modport slave (
    input  in_valid, a, b, signed_mode, out_ready,
    output in_ready, out_valid, p, busy
  );

  modport master (
    output in_valid, a, b, signed_mode, out_ready,
    input  in_ready, out_valid, p, busy
  );
endinterface

// File: rtl/iter_array_mult.sv
// Iterative WIDTH x WIDTH multiplier, unsigned or two's complement.
// It computes one partial-product row per clock using a single WIDTH-bit adder.
// Signed operands are reduced to magnitudes on entry. The sign is reapplied in a single FIX cycle.
module iter_array_mult #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  iter_array_mult_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

  state_t               state;
  state_t               state_next;
  logic [WIDTH-1:0]     mcand;
  logic [WIDTH-1:0]     mplier;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   p_reg;
  logic [CW-1:0]        count;
  logic                 neg;

  logic                 accept;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic [WIDTH-1:0]     addend;
  logic [WIDTH:0]       row_sum;

  // Operand magnitudes and the adder for the current row.
  // -2^(WIDTH-1) negates to itself, which reads correctly as an unsigned magnitude.
  always_comb begin
    accept  = (state == IDLE) && bus.in_valid;
    a_mag   = (bus.signed_mode && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    b_mag   = (bus.signed_mode && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    addend  = mplier[0] ? mcand : '0;
    row_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic. Each row takes one BUSY cycle, and rows are never skipped.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (bus.in_valid)              state_next = BUSY;
      BUSY: if (count == CW'(1))           state_next = FIX;
      FIX:                                 state_next = DONE;
      DONE: if (bus.out_ready)             state_next = IDLE;
      default:                             state_next = IDLE;
    endcase
  end

  // Output decodes come only from the state register.
  // They have no combinational path from in_valid or out_ready.
  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
    bus.busy      = (state == BUSY) || (state == FIX);
    bus.p         = p_reg;
  end

  // Datapath: capture on accept, then run shift-and-add rows in BUSY.
  // The sign is applied in FIX. p_reg changes only on the FIX edge, so it holds steady through DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      p_reg  <= '0;
      count  <= '0;
      neg    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            mcand  <= a_mag;
            mplier <= b_mag;
            acc    <= '0;
            count  <= CW'(WIDTH);
            neg    <= bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          end
        end
        BUSY: begin
          acc    <= {row_sum, acc[WIDTH-1:1]};
          mplier <= {acc[0], mplier[WIDTH-1:1]};
          count  <= count - CW'(1);
        end
        FIX: begin
          p_reg <= neg ? -acc : acc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_array_mult.sv
// Self-checking bench for iter_array_mult with one WIDTH=4 instance and one WIDTH=8 instance.
module tb_iter_array_mult;

  logic clk;
  logic rst_n;

  iter_array_mult_if #(.WIDTH(4)) if4 ();
  iter_array_mult_if #(.WIDTH(8)) if8 ();

  iter_array_mult #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
  iter_array_mult #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));

  typedef struct {
    string       name;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        sm;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [9];

  int n_checks;
  int n_fail;

  // Free-running clock with a 10-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop if the run ever stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Runs one WIDTH=8 operation. On return p is sampled while out_valid is high.
  task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input logic sm,
                               output logic [15:0] res, output bit ok);
    bit got_acc;
    bit got_out;
    got_acc = 1'b0;
    got_out = 1'b0;
    @(negedge clk);
    if8.a = av;
    if8.b = bv;
    if8.signed_mode = sm;
    if8.in_valid = 1'b1;
    for (int i = 0; i < 50 && !got_acc; i++) begin
      if (if8.in_ready) got_acc = 1'b1;
      else @(negedge clk);
    end
    @(negedge clk);
    if8.in_valid = 1'b0;
    for (int i = 0; i < 50 && !got_out; i++) begin
      if (if8.out_valid) got_out = 1'b1;
      else @(negedge clk);
    end
    res = if8.p;
    ok  = got_acc & got_out;
  endtask

  initial begin
    logic [15:0] res;
    bit          ok;
    bit          hold_ok;
    int          first_valid;
    int          busy_cnt;
    logic [7:0]  p4_seen;
    logic [7:0]  expq [$];
    int          n_rx;

    n_checks = 0;
    n_fail   = 0;
    n_rx     = 0;

    vecs[0] = '{"s -128*-128", 8'h80, 8'h80, 1'b1, 16'h4000};
    vecs[1] = '{"s -1*-1",     8'hFF, 8'hFF, 1'b1, 16'h0001};
    vecs[2] = '{"s -128*127",  8'h80, 8'h7F, 1'b1, 16'hC080};
    vecs[3] = '{"s 0*-5",      8'h00, 8'hFB, 1'b1, 16'h0000};
    vecs[4] = '{"s 127*-127",  8'h7F, 8'h81, 1'b1, 16'hC0FF};
    vecs[5] = '{"s -5*3",      8'hFB, 8'h03, 1'b1, 16'hFFF1};
    vecs[6] = '{"u 200*100",   8'hC8, 8'h64, 1'b0, 16'h4E20};
    vecs[7] = '{"u 255*255",   8'hFF, 8'hFF, 1'b0, 16'hFE01};
    vecs[8] = '{"u 128*0",     8'h80, 8'h00, 1'b0, 16'h0000};

    if4.in_valid = 1'b0; if4.a = '0; if4.b = '0; if4.signed_mode = 1'b0; if4.out_ready = 1'b1;
    if8.in_valid = 1'b0; if8.a = '0; if8.b = '0; if8.signed_mode = 1'b0; if8.out_ready = 1'b1;

    // Reset state.
    rst_n = 1'b0;
    #23;
    checkOutput("rst4 in_ready",  32'(if4.in_ready),  32'd1);
    checkOutput("rst4 out_valid", 32'(if4.out_valid), 32'd0);
    checkOutput("rst4 busy",      32'(if4.busy),      32'd0);
    checkOutput("rst4 p",         32'(if4.p),         32'd0);
    checkOutput("rst8 in_ready",  32'(if8.in_ready),  32'd1);
    checkOutput("rst8 out_valid", 32'(if8.out_valid), 32'd0);
    checkOutput("rst8 busy",      32'(if8.busy),      32'd0);
    checkOutput("rst8 p",         32'(if8.p),         32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // WIDTH=4 latency: 15*15, out_valid exactly 5 edges after accept.
    @(negedge clk);
    if4.a = 4'hF; if4.b = 4'hF; if4.signed_mode = 1'b0; if4.in_valid = 1'b1;
    @(posedge clk);
    first_valid = -1;
    busy_cnt    = 0;
    p4_seen     = '0;
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      if (j == 0) if4.in_valid = 1'b0;
      if (if4.busy) busy_cnt++;
      if (if4.out_valid && first_valid < 0) begin
        first_valid = j;
        p4_seen = if4.p;
      end
    end
    checkOutput("w4 latency",    32'(first_valid), 32'd5);
    checkOutput("w4 busy cycles", 32'(busy_cnt),   32'd5);
    checkOutput("w4 15*15",       32'(p4_seen),    32'hE1);

    // WIDTH=8 vector table.
    for (int v = 0; v < 9; v++) begin
      applyStimulus(vecs[v].a, vecs[v].b, vecs[v].sm, res, ok);
      checkOutput({vecs[v].name, " handshake"}, 32'(ok), 32'd1);
      checkOutput(vecs[v].name, 32'(res), 32'(vecs[v].exp));
    end

    // Hold in DONE with out_ready low. A second in_valid pulse must be ignored.
    @(negedge clk);
    if8.out_ready = 1'b0;
    applyStimulus(8'hFF, 8'hFF, 1'b0, res, ok);
    checkOutput("hold handshake", 32'(ok), 32'd1);
    checkOutput("hold 255*255", 32'(res), 32'hFE01);
    hold_ok = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 5) begin
        if8.a = 8'h03; if8.b = 8'h03; if8.in_valid = 1'b1;
      end
      if (k == 6) if8.in_valid = 1'b0;
      if (if8.p !== 16'hFE01 || if8.out_valid !== 1'b1 || if8.in_ready !== 1'b0) hold_ok = 1'b0;
    end
    checkOutput("hold stable", 32'(hold_ok), 32'd1);
    if8.out_ready = 1'b1;
    @(negedge clk);
    checkOutput("release in_ready",  32'(if8.in_ready),  32'd1);
    checkOutput("release out_valid", 32'(if8.out_valid), 32'd0);
    hold_ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (if8.busy !== 1'b0 || if8.p !== 16'hFE01) hold_ok = 1'b0;
    end
    checkOutput("ignored pulse not queued", 32'(hold_ok), 32'd1);

    // Reset pulse in BUSY cycle 3, then a clean 7*6.
    @(negedge clk);
    if8.a = 8'hFF; if8.b = 8'hFF; if8.signed_mode = 1'b0; if8.in_valid = 1'b1;
    @(negedge clk);
    if8.in_valid = 1'b0;
    checkOutput("abort busy", 32'(if8.busy), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort in_ready",  32'(if8.in_ready),  32'd1);
    checkOutput("abort out_valid", 32'(if8.out_valid), 32'd0);
    checkOutput("abort busy low",  32'(if8.busy),      32'd0);
    checkOutput("abort p",         32'(if8.p),         32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(8'h07, 8'h06, 1'b0, res, ok);
    checkOutput("post-abort handshake", 32'(ok), 32'd1);
    checkOutput("post-abort 7*6", 32'(res), 32'h002A);

    // WIDTH=4 sweep in both modes with random input and output gaps.
    fork
      begin
        int         gap;
        bit         got;
        int         ia;
        int         ib;
        logic [3:0] av;
        logic [3:0] bv;
        for (int m = 0; m < 2; m++) begin
          for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
              gap = $urandom_range(0, 2);
              for (int g = 0; g < gap; g++) @(negedge clk);
              av = 4'(ai);
              bv = 4'(bi);
              if4.a = av; if4.b = bv; if4.signed_mode = (m == 1); if4.in_valid = 1'b1;
              got = 1'b0;
              for (int t = 0; t < 100 && !got; t++) begin
                if (if4.in_ready) got = 1'b1;
                else @(negedge clk);
              end
              if (m == 1) begin
                ia = $signed(av);
                ib = $signed(bv);
              end else begin
                ia = int'(av);
                ib = int'(bv);
              end
              if (got) expq.push_back(8'(ia * ib));
              @(negedge clk);
              if4.in_valid = 1'b0;
            end
          end
        end
      end
      begin
        logic [7:0] e;
        for (int c = 0; c < 40000 && n_rx < 512; c++) begin
          @(negedge clk);
          if4.out_ready = 1'($urandom_range(0, 1));
          if (if4.out_valid && if4.out_ready) begin
            if (expq.size() == 0) begin
              checkOutput("sweep spurious result", 32'(if4.p), 32'hFFFF_FFFF);
            end else begin
              e = expq.pop_front();
              checkOutput("sweep product", 32'(if4.p), 32'(e));
            end
            n_rx++;
          end
        end
      end
    join
    checkOutput("sweep result count", 32'(n_rx), 32'd512);
    if4.out_ready = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
